// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_pkg
// Purpose  : Shared UART framing constants and receiver state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   localparam int CLKS_PER_BIT_DEFAULT = 33;
   // Bit times after the start bit: 7 data + 1 pad + 1 stop.
   localparam int FRAME_BITS = 9;
   localparam int DATA_BITS  = 7;
   localparam int SHIFT_W    = FRAME_BITS - 1;
   localparam int IDX_W      = $clog2(SHIFT_W);
   localparam int CNT_W      = 16;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 7-bit UART receiver (start, 7 data LSB first, pad, stop) with a
//            valid/ack handshake and sticky overrun / frame_err flags.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   input  logic                 ack,
   output logic                 overrun,
   output logic                 frame_err
);

   localparam logic [CNT_W-1:0] c_half     = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [CNT_W-1:0] c_last     = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(SHIFT_W - 1);

   logic               r_rx_meta;
   logic               r_rxs;
   logic               r_armed;
   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [IDX_W-1:0]   r_bit_idx;
   logic [SHIFT_W-1:0] r_shift;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rx_meta <= 1'b1;
         r_rxs     <= 1'b1;
         r_armed   <= 1'b1;
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         data      <= '0;
         valid     <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         r_rx_meta <= rx;
         r_rxs     <= r_rx_meta;

         if (valid && ack) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
         end

         case (r_state)
            // r_armed demands a high level before a start so a stuck-low line
            // yields one frame only.
            ST_IDLE: begin
               if (r_rxs) begin
                  r_armed <= 1'b1;
               end else if (r_armed) begin
                  r_armed <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= ST_START;
               end
            end
            ST_START: begin
               if (r_cnt == c_half) begin
                  if (!r_rxs) begin
                     r_cnt     <= '0;
                     r_bit_idx <= '0;
                     r_state   <= ST_DATA;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_DATA: begin
               if (r_cnt == c_last) begin
                  r_cnt     <= '0;
                  r_shift   <= {r_rxs, r_shift[SHIFT_W-1:1]};
                  r_bit_idx <= r_bit_idx + IDX_W'(1);
                  if (r_bit_idx == c_last_idx) begin
                     r_state <= ST_STOP;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_STOP: begin
               if (r_cnt == c_last) begin
                  r_cnt     <= '0;
                  r_state   <= ST_IDLE;
                  r_armed   <= r_rxs;
                  data      <= r_shift[DATA_BITS-1:0];
                  valid     <= 1'b1;
                  frame_err <= ~r_rxs;
                  // Overrides the ack clear above: a coincident ack leaves it as is.
                  overrun   <= overrun | (valid & ~ack);
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule : uart_rx
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 33: clk cycles per serial bit; legal range 4..65535.
REQ-002 clk  input  1  system clock; every register updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 rx  input  1  asynchronous serial line; idles high.
REQ-005 data  output  7  last received character, LSB = first data bit on the line.
REQ-006 valid  output  1  data holds an unconsumed character.
REQ-007 ack  input  1  consumer accepts data; only meaningful while valid=1.
REQ-008 overrun  output  1  sticky: a character was received while valid=1 and no ack was given.
REQ-009 frame_err  output  1  sticky: the most recent frame had stop bit = 0.

Function
REQ-010 Frame format: start bit 0, 7 data bits LSB first, 1 pad bit, 1 stop bit 1; 9 bit times after start-bit detection.
REQ-011 rx SHALL pass through a 2-flop synchronizer; all logic SHALL use the synchronized value rxs only.
REQ-012 States: IDLE, START, DATA, STOP; the state register and a baud counter at least 16 bits wide.
REQ-013 IDLE: when rxs=0, clear the baud counter and go to START.
REQ-014 START: at count CLKS_PER_BIT/2 (integer divide), sample rxs; if 0, clear the counter, clear the bit index and go to DATA; if 1, go to IDLE as a glitch with no flags changed.
REQ-015 DATA: sample rxs each time the counter reaches CLKS_PER_BIT-1, then clear the counter; shift the sample into an 8-bit shift register LSB-first; after 8 samples go to STOP.
REQ-016 The pad bit (8th sample) SHALL be discarded; its value SHALL NOT affect any output.
REQ-017 STOP: at count CLKS_PER_BIT-1, sample rxs, complete the frame, and go to IDLE in the same cycle, so the next start edge is detected during the second half of the stop bit.
REQ-018 On frame completion, the next cycle SHALL have data = shifted bits [6:0], valid=1, and frame_err = NOT(stop sample).
REQ-019 A frame with a bad stop bit SHALL still be delivered; frame_err flags it.
REQ-020 Handshake: ack while valid=1 SHALL clear valid next cycle; ack while valid=0 SHALL be ignored.
REQ-021 Completion while valid=1 and ack=0: data SHALL be overwritten, valid stays 1, and overrun is set.
REQ-022 Completion in the same cycle as ack: new data is loaded, valid stays 1, and overrun is unchanged.
REQ-023 overrun SHALL clear only on reset or on an ack that is not coincident with a new overrun.
REQ-024 frame_err SHALL update only at frame completion or reset.
REQ-025 A line held low SHALL produce one frame with frame_err=1, then wait in IDLE with no further frames until rxs returns high and falls again (IDLE requires a high-to-low edge).

Reset
REQ-026 reset SHALL force: state IDLE, counter 0, bit index 0, shift register 0, data 0, valid 0, overrun 0, frame_err 0, and synchronizer flops 1.
REQ-027 reset mid-frame SHALL abandon the frame with no valid pulse; reset has priority over all other events.

Structure
REQ-028 Shared package uart_pkg SHALL hold the state enumeration, the default CLKS_PER_BIT, and the frame bit count (9); the transmitter SHALL use the same constants.
REQ-029 Single module with no sub-modules; the 2-flop synchronizer SHALL be inline.

Verification
REQ-030 Drive frame 0x41 at 33 clks/bit (start, 1000001 LSB-first, pad 0, stop 1) -> data=7'h41, valid=1 one cycle after the stop sample, frame_err=0.
REQ-031 Low glitch of 10 clks on an idle line -> returns to IDLE, valid stays 0, and flags stay 0.
REQ-032 Two back-to-back frames 0x55 then 0x2A with no ack -> data=7'h2A, valid=1, overrun=1; then ack -> valid=0 and overrun=0 next cycle.
REQ-033 Frame 0x7F with stop bit 0 -> data=7'h7F, valid=1, frame_err=1; next good frame -> frame_err=0.
REQ-034 Assert reset at bit 4 of a frame, release, then send 0x12 -> no output from the aborted frame, then data=7'h12, valid=1.
REQ-035 Loopback with the transmitter at CLKS_PER_BIT=33 over all 128 codes, ack each -> every code received exactly, overrun=0, frame_err=0.
